// File: rtl/cu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cu_sequencer_pkg
//  Description : Shared types and constants for the control-unit sequencer:
//                phase encoding, status flag indices and the control-word
//                field offsets it shares with the R-type decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cu_sequencer_pkg;

    // Micro-state width shared with the decoder's state/NS fields
    localparam int SEQ_STATE_W = 4;

    // Width of the ALU status flag group {N,Z,C,V}
    localparam int STATUS_W = 4;

    // Sequencer phase encoding
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_FETCH = 2'd1,
        PH_EXEC  = 2'd2,
        PH_HALT  = 2'd3
    } phase_e;

    // Status flag bit positions
    localparam int STAT_N = 3;
    localparam int STAT_Z = 2;
    localparam int STAT_C = 1;
    localparam int STAT_V = 0;

    // Control-word field offsets common to decoder and sequencer
    localparam int CW_NS_LSB       = 0;
    localparam int CW_NS_W         = SEQ_STATE_W;
    localparam int CW_STATUS_LOAD  = CW_NS_LSB + CW_NS_W;
    localparam int CW_DP_LSB       = CW_STATUS_LOAD + 1;

    // Pack individual ALU flags into the {N,Z,C,V} status word
    function automatic logic [STATUS_W-1:0] pack_flags(
        input logic n,
        input logic z,
        input logic c,
        input logic v
    );
        logic [STATUS_W-1:0] f;
        f         = '0;
        f[STAT_N] = n;
        f[STAT_Z] = z;
        f[STAT_C] = c;
        f[STAT_V] = v;
        return f;
    endfunction

endpackage : cu_sequencer_pkg
`default_nettype wire

// File: rtl/cu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cu_sequencer_if
//  Description : Bundles the sequencer's memory handshake, decoder links and
//                datapath status signals. The master modport is the
//                sequencer; the slave modport is its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cu_sequencer_if #(
    parameter int IR_W    = 32,
    parameter int STATE_W = 4,
    parameter int CNT_W   = 16
) ();
    import cu_sequencer_pkg::*;

    // Environment to sequencer
    logic                run;
    logic                mem_ready;
    logic [IR_W-1:0]     mem_data;
    logic [STATE_W-1:0]  NS;
    logic                status_load;
    logic [STATUS_W-1:0] status_in;

    // Sequencer to environment
    logic                fetch_req;
    logic                pc_inc;
    logic [IR_W-1:0]     IR;
    logic [STATE_W-1:0]  state;
    logic [STATUS_W-1:0] status;
    logic                exec;
    logic                fetch_err;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  run, mem_ready, mem_data, NS, status_load, status_in,
        output fetch_req, pc_inc, IR, state, status, exec, fetch_err, retired
    );

    modport slave (
        output run, mem_ready, mem_data, NS, status_load, status_in,
        input  fetch_req, pc_inc, IR, state, status, exec, fetch_err, retired
    );

endinterface : cu_sequencer_if
`default_nettype wire

// File: rtl/cu_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cu_wait_timer
//  Description : Loadable saturating up-counter. The sequencer reloads it on
//                every phase change and uses it both as the fetch wait
//                counter and as the EXEC-length guard.
//  Revision    : 1.0 - initial release
// ============================================================================
module cu_wait_timer #(
    parameter int WIDTH = 5
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] load_val_i,
    input  wire logic             en_i,
    output logic      [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over counting; counting stops at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != CNT_MAX)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : cu_wait_timer
`default_nettype wire

// File: rtl/cu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cu_sequencer
//  Description : Control-unit sequencer. Fetches instruction words over a
//                req/ready handshake into IR, steps the micro-state from the
//                decoder's NS, latches ALU flags on status_load and counts
//                retired instructions. Fetch timeouts and runaway EXEC
//                sequences park the unit in HALT with fetch_err set.
//  Revision    : 1.0 - initial release
// ============================================================================
module cu_sequencer
    import cu_sequencer_pkg::*;
#(
    parameter int IR_W     = 32,
    parameter int STATE_W  = SEQ_STATE_W,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  wire logic           clock,
    input  wire logic           reset_n,
    cu_sequencer_if.master      bus
);

    // EXEC may last at most one pass through every micro-state
    localparam int EXEC_MAX = 1 << STATE_W;
    localparam int TMR_MAX  = (WAIT_MAX > EXEC_MAX) ? WAIT_MAX : EXEC_MAX;
    localparam int TIMER_W  = $clog2(TMR_MAX + 1);

    localparam logic [TIMER_W-1:0] FETCH_LAST = TIMER_W'(WAIT_MAX - 1);
    localparam logic [TIMER_W-1:0] EXEC_LAST  = TIMER_W'(EXEC_MAX - 1);

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a clock edge
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    // Two-stage release synchroniser for the external reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    phase_e              phase_q,     phase_d;
    logic [IR_W-1:0]     ir_q,        ir_d;
    logic [STATE_W-1:0]  state_q,     state_d;
    logic [STATUS_W-1:0] status_q,    status_d;
    logic [CNT_W-1:0]    retired_q,   retired_d;
    logic                fetch_err_q, fetch_err_d;

    logic                tmr_load;
    logic                tmr_en;
    logic [TIMER_W-1:0]  tmr_cnt;

    logic                in_fetch;
    logic                in_exec;
    logic                accept;

    assign in_fetch = (phase_q == PH_FETCH);
    assign in_exec  = (phase_q == PH_EXEC);
    assign accept   = in_fetch && bus.mem_ready;

    // ------------------------------------------------------------------
    // Shared wait / EXEC-length timer
    // ------------------------------------------------------------------
    cu_wait_timer #(
        .WIDTH      (TIMER_W)
    ) u_wait_timer (
        .clk_i      (clock),
        .rst_ni     (rst_n_int),
        .load_i     (tmr_load),
        .load_val_i ('0),
        .en_i       (tmr_en),
        .count_o    (tmr_cnt)
    );

    // Restart the timer on every phase change; it only runs in FETCH/EXEC
    always_comb begin
        tmr_load = (phase_d != phase_q) || (phase_q == PH_IDLE) || (phase_q == PH_HALT);
        tmr_en   = in_fetch || in_exec;
    end

    // Next phase and next values of IR, state, status, counters
    always_comb begin
        phase_d     = phase_q;
        ir_d        = ir_q;
        state_d     = state_q;
        status_d    = status_q;
        retired_d   = retired_q;
        fetch_err_d = fetch_err_q;

        case (phase_q)
            PH_IDLE: begin
                if (bus.run) begin
                    phase_d = PH_FETCH;
                end
            end

            PH_FETCH: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_data;
                    state_d = '0;
                    phase_d = PH_EXEC;
                end else if (tmr_cnt >= FETCH_LAST) begin
                    fetch_err_d = 1'b1;
                    phase_d     = PH_HALT;
                end
            end

            PH_EXEC: begin
                // The control word is applied every EXEC cycle, including
                // the one that completes the instruction
                state_d = bus.NS;
                if (bus.status_load) begin
                    status_d = bus.status_in;
                end
                if (bus.NS == '0) begin
                    retired_d = retired_q + CNT_W'(1);
                    phase_d   = bus.run ? PH_FETCH : PH_IDLE;
                end else if (tmr_cnt >= EXEC_LAST) begin
                    // Decoder never returned to state 0: treat as a hang
                    fetch_err_d = 1'b1;
                    phase_d     = PH_HALT;
                end
            end

            PH_HALT: begin
                phase_d = PH_HALT;
            end

            default: begin
                phase_d = PH_IDLE;
            end
        endcase
    end

    // Sequencer registers
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            phase_q     <= PH_IDLE;
            ir_q        <= '0;
            state_q     <= '0;
            status_q    <= '0;
            retired_q   <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            ir_q        <= ir_d;
            state_q     <= state_d;
            status_q    <= status_d;
            retired_q   <= retired_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: strobes decode from phase, everything else is registered
    // ------------------------------------------------------------------
    assign bus.fetch_req = in_fetch;
    assign bus.pc_inc    = accept;
    assign bus.exec      = in_exec;
    assign bus.IR        = ir_q;
    assign bus.state     = state_q;
    assign bus.status    = status_q;
    assign bus.fetch_err = fetch_err_q;
    assign bus.retired   = retired_q;

endmodule : cu_sequencer
`default_nettype wire

// File: tb/tb_cu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cu_sequencer
//  Description : Self-checking bench for cu_sequencer. A transaction-level
//                reference model (fetching / executing / halted flags with
//                plain integer counters) tracks the expected behaviour
//                under directed scenarios and randomised stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cu_sequencer;
    import cu_sequencer_pkg::*;

    localparam int IR_W     = 32;
    localparam int STATE_W  = 4;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;     // small counter so wrap is reachable
    localparam int EXEC_CAP = 16;    // 2**STATE_W

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    cu_sequencer_if #(
        .IR_W    (IR_W),
        .STATE_W (STATE_W),
        .CNT_W   (CNT_W)
    ) bus ();

    cu_sequencer #(
        .IR_W     (IR_W),
        .STATE_W  (STATE_W),
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit          m_fetching, m_executing, m_halted, m_err;
    int          m_wait, m_exec_len, m_retired;
    logic [31:0] m_ir;
    logic [3:0]  m_state, m_status;

    task automatic model_reset();
        m_fetching  = 0;
        m_executing = 0;
        m_halted    = 0;
        m_err       = 0;
        m_wait      = 0;
        m_exec_len  = 0;
        m_retired   = 0;
        m_ir        = '0;
        m_state     = '0;
        m_status    = '0;
    endtask

    // One clock edge worth of behaviour, using the inputs held before the edge
    task automatic model_step();
        if (m_halted) begin
            // only reset leaves HALT
        end else if (m_fetching) begin
            m_wait++;
            if (bus.mem_ready) begin
                m_ir        = bus.mem_data;
                m_state     = '0;
                m_fetching  = 0;
                m_executing = 1;
                m_exec_len  = 0;
            end else if (m_wait >= WAIT_MAX) begin
                m_err      = 1;
                m_halted   = 1;
                m_fetching = 0;
            end
        end else if (m_executing) begin
            m_exec_len++;
            m_state = bus.NS;
            if (bus.status_load) m_status = bus.status_in;
            if (bus.NS == 0) begin
                m_retired   = (m_retired + 1) % (1 << CNT_W);
                m_executing = 0;
                m_fetching  = bus.run;
                m_wait      = 0;
            end else if (m_exec_len >= EXEC_CAP) begin
                m_err       = 1;
                m_halted    = 1;
                m_executing = 0;
            end
        end else if (bus.run) begin
            m_fetching = 1;
            m_wait     = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    bit last_fetch_req, last_pc_inc, last_exec;

    task automatic drive(input bit r, input bit rdy, input logic [31:0] d,
                         input logic [3:0] ns, input bit sl, input logic [3:0] si);
        bus.run         = r;
        bus.mem_ready   = rdy;
        bus.mem_data    = d;
        bus.NS          = ns;
        bus.status_load = sl;
        bus.status_in   = si;
    endtask

    task automatic check_regs();
        chk("IR",        bus.IR,        m_ir);
        chk("state",     bus.state,     m_state);
        chk("status",    bus.status,    m_status);
        chk("fetch_err", bus.fetch_err, m_err);
        chk("retired",   bus.retired,   m_retired);
    endtask

    task automatic check_strobes();
        chk("fetch_req", bus.fetch_req, m_fetching);
        chk("pc_inc",    bus.pc_inc,    m_fetching && bus.mem_ready);
        chk("exec",      bus.exec,      m_executing);
    endtask

    // Check strobes with current inputs, clock once, check registers
    task automatic cycle();
        #2;
        check_strobes();
        last_fetch_req = bus.fetch_req;
        last_pc_inc    = bus.pc_inc;
        last_exec      = bus.exec;
        @(posedge clock);
        model_step();
        #1;
        check_regs();
    endtask

    task automatic do_reset();
        drive(0, 0, '0, '0, 0, '0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_regs();
        check_strobes();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) cycle();
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main
        int cnt_a, cnt_b;
        logic [31:0] word;

        model_reset();

        // Reset with run low: everything stays zero in IDLE
        do_reset();
        for (int i = 0; i < 10; i++) cycle();
        chk("rst_IR",        bus.IR,        32'h0);
        chk("rst_retired",   bus.retired,   4'h0);
        chk("rst_fetch_req", bus.fetch_req, 1'b0);

        // Zero-wait fetch
        do_reset();
        drive(1, 1, 32'h8B02_0020, 4'd0, 1, 4'b0100);
        cycle();                                  // IDLE -> FETCH
        cycle();                                  // accept
        chk("zw_IR",     bus.IR, 32'h8B02_0020);
        cycle();                                  // single EXEC cycle
        chk("zw_status", bus.status, 4'b0100);
        chk("zw_retired", bus.retired, 4'd1);
        cnt_a = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (last_pc_inc) cnt_a++;
        end
        chk("zw_pc_inc_rate", cnt_a, 4);

        // Wait states: ready arrives on the fourth FETCH cycle
        do_reset();
        drive(1, 0, 32'hDEAD_BEEF, 4'd0, 0, 4'h0);
        cycle();
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (last_fetch_req) cnt_a++;
            if (last_pc_inc)    cnt_b++;
        end
        chk("ws_IR_hold", bus.IR, 32'h0);
        drive(0, 1, 32'h1234_5678, 4'd0, 0, 4'h0);
        cycle();
        if (last_fetch_req) cnt_a++;
        if (last_pc_inc)    cnt_b++;
        drive(0, 0, 32'hFFFF_FFFF, 4'd0, 0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (last_fetch_req) cnt_a++;
            if (last_pc_inc)    cnt_b++;
        end
        chk("ws_fetch_cycles", cnt_a, 4);
        chk("ws_pc_inc",       cnt_b, 1);
        chk("ws_IR",           bus.IR, 32'h1234_5678);

        // Fetch timeout
        do_reset();
        drive(1, 0, 32'hAAAA_5555, 4'd0, 0, 4'h0);
        cycle();
        for (int i = 0; i < WAIT_MAX; i++) cycle();
        chk("to_fetch_err", bus.fetch_err, 1'b1);
        cnt_a = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (last_fetch_req) cnt_a++;
        end
        chk("to_req_after_halt", cnt_a, 0);
        chk("to_IR", bus.IR, 32'h0);
        do_reset();
        chk("to_err_cleared", bus.fetch_err, 1'b0);

        // Multi-state instruction, run dropped during the second EXEC cycle
        do_reset();
        drive(1, 1, 32'hCAFE_0001, 4'd0, 0, 4'h0);
        cycle();
        cycle();                                   // accept
        drive(1, 0, 32'h0, 4'd2, 0, 4'h0);
        cnt_a = 0;
        chk("ms_state0", bus.state, 4'd0);
        cycle(); if (last_exec) cnt_a++;
        chk("ms_state1", bus.state, 4'd2);
        drive(0, 0, 32'h0, 4'd3, 1, 4'b1010);
        cycle(); if (last_exec) cnt_a++;
        chk("ms_state2", bus.state, 4'd3);
        drive(0, 0, 32'h0, 4'd0, 0, 4'h0);
        cycle(); if (last_exec) cnt_a++;
        cnt_b = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (last_exec || last_fetch_req) cnt_b++;
        end
        chk("ms_exec_cycles", cnt_a, 3);
        chk("ms_idle_after",  cnt_b, 0);
        chk("ms_retired",     bus.retired, 4'd1);
        chk("ms_status",      bus.status, 4'b1010);

        // EXEC-length guard: NS never returns to 0
        do_reset();
        drive(1, 1, 32'h0BAD_0BAD, 4'd5, 0, 4'h0);
        cycle();
        cycle();
        for (int i = 0; i < EXEC_CAP; i++) cycle();
        chk("ovf_fetch_err", bus.fetch_err, 1'b1);
        cycle();
        chk("ovf_exec_low", last_exec, 1'b0);

        // Retired counter wrap
        do_reset();
        drive(1, 1, 32'h0000_0F0F, 4'd0, 0, 4'h0);
        cycle();
        for (int i = 0; i < 2 * 15; i++) cycle();
        chk("wrap_pre", bus.retired, 4'd15);
        cycle();
        cycle();
        chk("wrap_zero", bus.retired, 4'd0);

        // Randomised traffic with varying memory latency
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            int rdy_pct;
            rdy_pct = (blk % 3 == 0) ? 90 : ((blk % 3 == 1) ? 40 : 15);
            for (int i = 0; i < 500; i++) begin
                word = $urandom();
                drive(($urandom_range(0, 99) < 85),
                      ($urandom_range(0, 99) < rdy_pct),
                      word,
                      ($urandom_range(0, 99) < 55) ? 4'd0 : 4'($urandom_range(1, 15)),
                      ($urandom_range(0, 1) == 1),
                      4'($urandom_range(0, 15)));
                cycle();
                if (m_halted && ($urandom_range(0, 9) == 0)) do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cu_sequencer
`default_nettype wire
